// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core and its operand feeder.
// Holds the datapath width and the feeder state encoding.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_A = 3'd1,
    REL_A = 3'd2,
    REQ_B = 3'd3,
    OUT   = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/gcd_timeout_cnt.sv
// Watchdog for a single core acknowledge wait.
// expired is high in the TIMEOUT-th enabled cycle after the last clear.
module gcd_timeout_cnt #(
  parameter int TIMEOUT = 262143
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at LAST so a stalled wait keeps reporting expiry instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/gcd_feeder.sv
// Serialises an (A, B) operand pair onto the GCD core's req/ack bus and
// returns the result on a valid/ready port; zero operands bypass the core.
module gcd_feeder
  import gcd_pkg::*;
#(
  parameter int REQ_HOLD = 2,
  parameter int TIMEOUT  = 262143
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [GCD_WIDTH-1:0] in_a,
  input  logic [GCD_WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [GCD_WIDTH-1:0] out_c,
  output logic                 out_err,
  output logic                 gcd_req,
  output logic [GCD_WIDTH-1:0] gcd_ab,
  input  logic                 gcd_ack,
  input  logic [GCD_WIDTH-1:0] gcd_c
);

  localparam int HW = $clog2(REQ_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REQ_HOLD - 1);

  feeder_state_t        state_q, state_d;
  logic [GCD_WIDTH-1:0] a_q, a_d;
  logic [GCD_WIDTH-1:0] b_q, b_d;
  logic [GCD_WIDTH-1:0] c_q, c_d;
  logic                 err_q, err_d;
  logic [HW-1:0]        hold_q, hold_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  gcd_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  assign timer_en = (state_q == REL_A) || (state_q == REQ_B);

  // Both ports: a transfer happens on the rising edge where valid and ready
  // are both 1; valid and its payload stay stable until that edge.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    err_d       = err_q;
    hold_d      = hold_q;
    timer_clear = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          // The subtractive core never terminates on a zero operand.
          if ((in_a == '0) || (in_b == '0)) begin
            c_d     = in_a | in_b;
            err_d   = 1'b0;
            state_d = OUT;
          end else begin
            state_d = REQ_A;
          end
        end
      end
      REQ_A: begin
        if (hold_q == HOLD_LAST) begin
          timer_clear = 1'b1;
          state_d     = REL_A;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      REL_A: begin
        if (gcd_ack) begin
          timer_clear = 1'b1;
          state_d     = REQ_B;
        end else if (timer_expired) begin
          c_d     = '0;
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      REQ_B: begin
        // An ack in the expiry cycle still delivers a valid result.
        if (gcd_ack) begin
          c_d     = gcd_c;
          err_d   = 1'b0;
          state_d = OUT;
        end else if (timer_expired) begin
          c_d     = '0;
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_c     = c_q;
  assign out_err   = err_q;
  assign gcd_req   = (state_q == REQ_A) || (state_q == REQ_B);
  assign gcd_ab    = ((state_q == REQ_A) || (state_q == REL_A)) ? a_q :
                     (state_q == REQ_B) ? b_q : '0;

endmodule

// File: doc/gcd_feeder.md
# gcd_feeder

Operand sequencer that sits directly upstream of the GCD core. It accepts an operand pair (A, B) from a valid/ready source and serialises it onto the core's single 16-bit `AB` bus using the core's req/ack protocol. It captures the result `C` on the core's result ack and presents it downstream on a valid/ready port. It also short-circuits zero operands, which the subtractive core cannot terminate on, and flags a core that never answers.

## Interface
- `REQ_HOLD`, default 2: cycles `gcd_req` stays high with A on the bus; must be ≥2.
- `TIMEOUT`, default 262143: max cycles waiting for any single `gcd_ack`; must be ≥1.
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `in_valid`  in  1  operand pair available.
- `in_ready`  out  1  feeder can accept a pair.
- `in_a`, `in_b`  in  16 each  unsigned operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_c`  out  16  gcd(A,B), or 0 on error.
- `out_err`  out  1  result invalid (core timeout); qualified by `out_valid`.
- `gcd_req`  out  1  to core `req`.
- `gcd_ab`  out  16  to core `AB`.
- `gcd_ack`  in  1  from core `ack`.
- `gcd_c`  in  16  from core `C`, valid only while `gcd_ack`=1.

## Operation
- FSM states: IDLE, REQ_A, REL_A, REQ_B, OUT.
- IDLE: `in_ready`=1. On `in_valid`: latch `in_a`/`in_b` into `a_q`/`b_q`.
  - If either operand is 0: result = `a_q | b_q` (gcd(x,0)=x, gcd(0,0)=0), `err`=0, go to OUT. The core is never touched.
  - Otherwise go to REQ_A.
- REQ_A: `gcd_req`=1, `gcd_ab`=`a_q`, for exactly `REQ_HOLD` cycles (hold counter), then REL_A.
- REL_A: `gcd_req`=0, `gcd_ab`=`a_q`; on `gcd_ack`=1 go to REQ_B.
- REQ_B: `gcd_req`=1, `gcd_ab`=`b_q` until `gcd_ack`=1. That cycle: capture `gcd_c`, `err`=0, go to OUT.
- OUT: `out_valid`=1, `out_c`/`out_err` from registers, held stable until `out_ready`=1, then IDLE.
- Outside REQ_A/REL_A/REQ_B: `gcd_req`=0, `gcd_ab`=0.
- Timeout:
  - One counter clears on entry to REL_A and again on entry to REQ_B, and increments each cycle in those states.
  - When it reaches `TIMEOUT` with no ack: result=0, `err`=1, go to OUT.
  - The core is left mid-transaction; system-level reset is required before reuse. The feeder itself resumes normally.
- `gcd_ack` outside REL_A/REQ_B is ignored.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - `gcd_req`=0, `gcd_ab`=0, `out_valid`=0, `out_c`=0, `out_err`=0, all data registers 0.
  - `in_ready`=1 (decoded from IDLE).
  - No transfer is accepted while `reset`=0.
- Reset mid-operation, any state: same values, next cycle after release is IDLE. A core transaction in flight is abandoned.
- Transfer occurs on the edge where valid=1 and ready=1; at most one pair in flight. `in_ready`=0 from the cycle after accept until back in IDLE.
- Bypass latency: accept on edge k, `out_valid`=1 in cycle k+1.
- Core path:
  - `gcd_req` rises in the cycle after accept, stays high exactly `REQ_HOLD` cycles, then drops.
  - REQ_B starts in the cycle after the A-ack. `gcd_req` falls in the cycle after the result ack.
- Simultaneous `gcd_ack` and timeout on the same cycle: ack wins.
- Back-to-back: OUT→IDLE on `out_ready` costs one cycle, so max throughput is one pair per (core latency + `REQ_HOLD` + 4) cycles.
- `out_valid` deasserts in the cycle after the `out_ready` handshake.

## Structure
- Shared package `gcd_pkg`:
  - `GCD_WIDTH` = 16.
  - `feeder_state_t` enum (IDLE, REQ_A, REL_A, REQ_B, OUT).
  - Reused by the core bench and any core-side FSM.
- One sub-module, `gcd_timeout_cnt`:
  - Ports: `clk`, `reset`, `clear`, `enable`, `expired`.
  - Width $clog2(`TIMEOUT`+1).
  - Same async active-low reset.
- All remaining logic (FSM, hold counter, operand/result registers) lives in `gcd_feeder`.
- Outputs come from registers or decode of registered state only. There are no combinational paths from `in_valid`/`out_ready` to outputs.

## Test plan
- (48,18), core model acks A after 1 cycle:
  - `gcd_req` high exactly 2 cycles with `gcd_ab`=48, then low.
  - B phase shows `gcd_ab`=18.
  - `out_c`=6, `out_err`=0.
- (0,35), then (0,0), then (65535,0):
  - Results 35, 0, 65535, each with `out_valid` one cycle after accept.
  - `gcd_req` never asserts.
- (65535,1) with real core and `out_ready` held 0 for 10 cycles after `out_valid`:
  - `out_c`=1 stable throughout, `in_ready`=0.
  - No timeout at default `TIMEOUT`.
- Core model never acks B, `TIMEOUT`=100:
  - Exactly 100 cycles in REQ_B, then `out_valid`=1, `out_err`=1, `out_c`=0.
  - Next pair (9,6) through a fresh core gives 3.
- `reset` pulled low during REQ_B:
  - `gcd_req`, `out_valid` to 0 the same cycle.
  - `in_ready`=1.
  - After release, (12,8) gives 4.
- `in_valid` held high with pairs (21,14), (17,5), (100,75), `out_ready`=1:
  - Outputs 7, 1, 25 in order, none lost or duplicated.
